// File: rtl/stp_block_packer.sv
// Serial-to-parallel message-block assembler: collects DEPTH words into one
// DEPTH x WORD_W block with early termination, zero padding and byte swap.
module stp_block_packer #(
    parameter int WORD_W     = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 5,
    parameter int FIRST_HIGH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_word,
    input  logic                    in_last,
    input  logic                    swap_bytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*DEPTH-1:0] out_block,
    output logic [CNT_W-1:0]        out_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NBYTE = WORD_W / 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WORD_W-1:0]  slots_r [DEPTH];
    logic [IDX_W-1:0]   wr_idx_s;
    logic [WORD_W-1:0]  wr_data_s;
    logic               accept_s;
    logic               block_done_s;

    function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w,
                                                    input logic en);
        logic [WORD_W-1:0] r;
        r = w;
        if (en) begin
            for (int b = 0; b < NBYTE; b++) begin
                r[b*8 +: 8] = w[(NBYTE-1-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    // Slot selection and write-data shaping for the word being accepted.
    always_comb begin
        if (FIRST_HIGH != 0) begin
            wr_idx_s = IDX_W'(DEPTH - 1) - ptr_r[IDX_W-1:0];
        end else begin
            wr_idx_s = ptr_r[IDX_W-1:0];
        end
        wr_data_s    = byte_swap(in_word, swap_bytes);
        accept_s     = in_valid && in_ready_r && (state_r == FILL);
        block_done_s = in_last || (ptr_r == CNT_W'(DEPTH - 1));
    end

    // Block state, storage, pointer and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILL;
            ptr_r       <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) slots_r[i] <= '0;
        end else if (clear) begin
            state_r     <= FILL;
            ptr_r       <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) slots_r[i] <= '0;
        end else begin
            case (state_r)
                FILL: begin
                    // in_ready_r is held low only for the first cycle after reset.
                    if (accept_s) begin
                        slots_r[wr_idx_s] <= wr_data_s;
                        if (block_done_s) begin
                            state_r     <= HOLD;
                            count_r     <= ptr_r + CNT_W'(1);
                            ptr_r       <= '0;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + CNT_W'(1);
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                HOLD: begin
                    // Zeroing on release gives the next block its padding for free.
                    if (out_ready) begin
                        state_r     <= FILL;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) slots_r[i] <= '0;
                    end
                end
                default: begin
                    state_r     <= FILL;
                    ptr_r       <= '0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_pack
            assign out_block[g*WORD_W +: WORD_W] = slots_r[g];
        end
    endgenerate

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_count = count_r;

endmodule
